// File: rtl/vote_input_conditioner_pkg.sv
// Shared types and helpers for the ballot-panel front end.
package vm_pkg;

    localparam int CAND_W           = 2;
    localparam int N_CAND           = 4;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef logic [CAND_W-1:0] cand_id_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    // Index of the highest set bit; only meaningful for a one-hot input.
    function automatic cand_id_t onehot_to_id(input logic [N_CAND-1:0] oh);
        cand_id_t id;
        id = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (oh[i]) id = cand_id_t'(i);
        end
        return id;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [N_CAND-1:0] v);
        return (v != '0) && ((v & (v - N_CAND'(1))) == '0);
    endfunction

endpackage

// File: rtl/vote_input_conditioner_if.sv
// Raw panel inputs and conditioned vote outputs between panel and votingMachine.
interface vote_input_conditioner_if;
    import vm_pkg::*;

    logic     mode;
    logic     button1;
    logic     button2;
    logic     button3;
    logic     button4;
    logic     vote_valid;
    cand_id_t vote_id;
    logic     conflict;
    logic     mode_stable;

    // Panel / consumer side.
    modport master (
        output mode, button1, button2, button3, button4,
        input  vote_valid, vote_id, conflict, mode_stable
    );

    // Conditioner side.
    modport slave (
        input  mode, button1, button2, button3, button4,
        output vote_valid, vote_id, conflict, mode_stable
    );

endinterface

// File: rtl/vote_input_conditioner_debounce_ch.sv
// One input channel: 2-flop synchroniser, debounce counter, stable level and
// a one-cycle rise pulse on each accepted 0->1 transition.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    // Counter reaching this value on a mismatch means the new level has been
    // held for DEBOUNCE_CYCLES synced cycles, so the toggle lands on that edge.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Synchronise, count consecutive mismatching cycles, toggle when held long enough.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= ~stable;
                rise   <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vote_input_conditioner.sv
// Conditions four candidate buttons and the mode switch, and turns each
// accepted single-button press into one vote strobe.
module vote_input_conditioner
    import vm_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    vote_input_conditioner_if.slave  bus
);

    logic [N_CAND-1:0] btn_raw;
    logic [N_CAND-1:0] btn_stable;
    logic [N_CAND-1:0] btn_rise;
    logic              mode_rise_unused;

    assign btn_raw = {bus.button4, bus.button3, bus.button2, bus.button1};

    for (genvar g = 0; g < N_CAND; g++) begin : g_btn
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .raw    (btn_raw[g]),
            .stable (btn_stable[g]),
            .rise   (btn_rise[g])
        );
    end

    // Mode is only a level for the downstream; its rise pulse has no consumer.
    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_mode (
        .clock  (clock),
        .reset  (reset),
        .raw    (bus.mode),
        .stable (bus.mode_stable),
        .rise   (mode_rise_unused)
    );

    arb_state_t state, state_nxt;
    logic       vote_valid_nxt;
    logic       conflict_nxt;
    cand_id_t   vote_id_nxt;

    // Arbiter: first rise in IDLE decides vote or conflict, then stay locked
    // until every button has been released.
    always_comb begin
        state_nxt      = state;
        vote_valid_nxt = 1'b0;
        conflict_nxt   = 1'b0;
        vote_id_nxt    = bus.vote_id;
        case (state)
            IDLE: begin
                if (|btn_rise) begin
                    state_nxt = LOCKED;
                    if (is_onehot(btn_stable)) begin
                        vote_valid_nxt = 1'b1;
                        vote_id_nxt    = onehot_to_id(btn_stable);
                    end else begin
                        conflict_nxt = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (btn_stable == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state and registered strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            bus.vote_valid <= 1'b0;
            bus.conflict   <= 1'b0;
            bus.vote_id    <= '0;
        end else begin
            state          <= state_nxt;
            bus.vote_valid <= vote_valid_nxt;
            bus.conflict   <= conflict_nxt;
            bus.vote_id    <= vote_id_nxt;
        end
    end

endmodule
